// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the EX-stage forwarding and load-use stall unit.
// Register-index and word types are reused by every file of the block.
package fwd_hazard_unit_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] rv32i_reg;
    typedef logic [31:0]      rv32i_word;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } fwd_state_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the pipeline and the forwarding/hazard unit.
// ex_valid qualifies EX, stall holds IF/ID/EX, dmem_resp is a one-cycle data-valid pulse.
interface fwd_hazard_unit_if
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 2,
    parameter int XLEN    = 32,
    parameter int CNT_W   = 16
) ();

    logic                     flush;
    logic                     ex_valid;
    logic [NUM_SRC*REG_W-1:0] ex_rs;
    logic [NUM_STG-1:0]       stg_valid;
    logic [NUM_STG*REG_W-1:0] stg_rd;
    logic [NUM_STG-1:0]       stg_is_load;
    logic [NUM_STG*XLEN-1:0]  stg_data;
    logic                     dmem_resp;
    logic [XLEN-1:0]          dmem_rdata;

    logic [NUM_SRC-1:0]       fwd_hit;
    logic [NUM_SRC*XLEN-1:0]  fwd_data;
    logic                     stall;
    logic [CNT_W-1:0]         stall_cnt;
    fwd_state_t               dbg_state;
    logic                     dbg_hold_valid;

    modport master (
        output flush, ex_valid, ex_rs, stg_valid, stg_rd, stg_is_load, stg_data,
               dmem_resp, dmem_rdata,
        input  fwd_hit, fwd_data, stall, stall_cnt, dbg_state, dbg_hold_valid
    );

    modport slave (
        input  flush, ex_valid, ex_rs, stg_valid, stg_rd, stg_is_load, stg_data,
               dmem_resp, dmem_rdata,
        output fwd_hit, fwd_data, stall, stall_cnt, dbg_state, dbg_hold_valid
    );

endinterface

// File: rtl/fwd_hazard_unit_match_mux.sv
// Priority match and value select for one EX source operand.
// Order: pending load data, then youngest matching stage, then the hold register.
module fwd_match_mux
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_STG = 2,
    parameter int XLEN    = 32
) (
    input  rv32i_reg                 i_rs,
    input  logic [NUM_STG-1:0]       i_stg_valid,
    input  logic [NUM_STG*REG_W-1:0] i_stg_rd,
    input  logic [NUM_STG-1:0]       i_stg_is_load,
    input  logic [NUM_STG*XLEN-1:0]  i_stg_data,
    input  logic                     i_pend_active,
    input  rv32i_reg                 i_pend_rd,
    input  logic                     i_hold_valid,
    input  rv32i_reg                 i_hold_rd,
    input  logic [XLEN-1:0]          i_hold_data,
    input  logic [XLEN-1:0]          i_dmem_rdata,
    output logic                     o_hit,
    output logic [XLEN-1:0]          o_data,
    output logic                     o_load_use
);

    logic            w_found;
    logic            w_win_load;
    logic [XLEN-1:0] w_win_data;

    always_comb begin
        w_found    = 1'b0;
        w_win_load = 1'b0;
        w_win_data = '0;
        // Walk oldest to youngest so the lowest-index match is the one left standing.
        for (int s = NUM_STG - 1; s >= 0; s--) begin
            if (i_stg_valid[s] && (i_stg_rd[s*REG_W +: REG_W] == i_rs)) begin
                w_found    = 1'b1;
                w_win_load = (s == 0) && i_stg_is_load[s];
                w_win_data = i_stg_data[s*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        o_hit      = 1'b0;
        o_data     = '0;
        o_load_use = 1'b0;
        if (i_rs != '0) begin
            if (i_pend_active && (i_rs == i_pend_rd)) begin
                o_hit  = 1'b1;
                o_data = i_dmem_rdata;
            end else if (w_found) begin
                o_hit = 1'b1;
                if (w_win_load) begin
                    o_data     = i_dmem_rdata;
                    o_load_use = 1'b1;
                end else begin
                    o_data = w_win_data;
                end
            end else if (i_hold_valid && (i_hold_rd == i_rs)) begin
                o_hit  = 1'b1;
                o_data = i_hold_data;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding with load-use stall FSM, post-load hold register
// and a saturating stall-cycle counter.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 2,
    parameter int XLEN    = 32,
    parameter int CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    fwd_hazard_unit_if.slave bus
);

    fwd_state_t         r_state;
    fwd_state_t         w_state_nxt;
    logic               r_hold_valid;
    rv32i_reg           r_hold_rd;
    logic [XLEN-1:0]    r_hold_data;
    rv32i_reg           r_pend_rd;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_pend_active;
    logic               w_hazard;
    logic               w_stall;
    logic               w_enter_wait;
    logic               w_hold_load;
    logic [NUM_SRC-1:0] w_hit;
    logic [NUM_SRC-1:0] w_load_use;
    logic [XLEN-1:0]    w_data [NUM_SRC];

    assign w_pend_active = (r_state == LOAD_WAIT);

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_match_mux #(
                .NUM_STG (NUM_STG),
                .XLEN    (XLEN)
            ) u_match (
                .i_rs          (bus.ex_rs[i*REG_W +: REG_W]),
                .i_stg_valid   (bus.stg_valid),
                .i_stg_rd      (bus.stg_rd),
                .i_stg_is_load (bus.stg_is_load),
                .i_stg_data    (bus.stg_data),
                .i_pend_active (w_pend_active),
                .i_pend_rd     (r_pend_rd),
                .i_hold_valid  (r_hold_valid),
                .i_hold_rd     (r_hold_rd),
                .i_hold_data   (r_hold_data),
                .i_dmem_rdata  (bus.dmem_rdata),
                .o_hit         (w_hit[i]),
                .o_data        (w_data[i]),
                .o_load_use    (w_load_use[i])
            );
            assign bus.fwd_data[i*XLEN +: XLEN] = w_data[i];
        end
    endgenerate

    assign w_hazard = bus.ex_valid && (r_state == IDLE) && (|w_load_use);

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                // Data arriving in the hazard cycle is forwarded directly, so no stall.
                if (!bus.flush && w_hazard && !bus.dmem_resp) begin
                    w_stall     = 1'b1;
                    w_state_nxt = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (bus.flush || bus.dmem_resp) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_enter_wait = (r_state == IDLE) && (w_state_nxt == LOAD_WAIT);
    assign w_hold_load  = (r_state == LOAD_WAIT) && bus.dmem_resp && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_rd <= '0;
        end else if (w_enter_wait) begin
            r_pend_rd <= bus.stg_rd[REG_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_rd    <= '0;
            r_hold_data  <= '0;
        end else if (bus.flush) begin
            r_hold_valid <= 1'b0;
        end else if (w_hold_load) begin
            r_hold_valid <= 1'b1;
            r_hold_rd    <= r_pend_rd;
            r_hold_data  <= bus.dmem_rdata;
        end else if (bus.ex_valid && !w_stall) begin
            r_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.fwd_hit        = w_hit;
    assign bus.stall          = w_stall;
    assign bus.stall_cnt      = r_stall_cnt;
    assign bus.dbg_state      = r_state;
    assign bus.dbg_hold_valid = r_hold_valid;

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of EX source-register ports (≥1).
REQ-002 SHALL have parameter NUM_STG, default 2, number of downstream forwarding stages; index 0 = youngest (MEM), highest priority.
REQ-003 SHALL have parameter XLEN, default 32, data width.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports:
- flush  in  1  pipeline flush
- ex_valid  in  1  EX holds a real instruction
- ex_rs  in  NUM_SRC*5  EX source indices
- stg_valid  in  NUM_STG  stage holds a writing instruction
- stg_rd  in  NUM_STG*5  stage destination indices
- stg_is_load  in  NUM_STG  stage instruction is a load
- stg_data  in  NUM_STG*XLEN  stage result value
- dmem_resp  in  1  load data valid this cycle
- dmem_rdata  in  XLEN  load data
- fwd_hit  out  NUM_SRC  source is forwarded
- fwd_data  out  NUM_SRC*XLEN  forwarded value
- stall  out  1  hold IF/ID/EX
- stall_cnt  out  CNT_W  saturating stall-cycle count

Function
REQ-007 Per source i: if ex_rs[i]==0, fwd_hit[i]=0 and fwd_data[i]=0.
REQ-008 Otherwise, the lowest stage s with stg_valid[s], stg_rd[s]==ex_rs[i] and stg_rd[s]!=0 SHALL win: fwd_hit=1, fwd_data=stg_data[s], unless that stage is a load (REQ-010).
REQ-009 With no stage match and hold_valid with hold_rd==ex_rs[i], fwd_hit=1 and fwd_data=hold_data. Otherwise fwd_hit=0.
REQ-010 The stall FSM SHALL have states IDLE and LOAD_WAIT.
REQ-011 IDLE: a load-use hazard exists when ex_valid is high and any nonzero source's winning stage is 0 with stg_is_load[0]=1.
REQ-012 In IDLE, on a hazard, stall=1 combinationally, pend_rd<=stg_rd[0], and the FSM moves to LOAD_WAIT.
REQ-013 In IDLE, a hazard with dmem_resp=1 in the same cycle SHALL NOT stall; dmem_rdata is forwarded instead.
REQ-014 LOAD_WAIT: stall=~dmem_resp, and sources matching pend_rd get fwd_data=dmem_rdata with priority over all stages.
REQ-015 LOAD_WAIT, on dmem_resp: hold_valid<=1, hold_rd<=pend_rd, hold_data<=dmem_rdata, and the FSM moves to IDLE.
REQ-016 hold_valid SHALL clear on the clock edge after ex_valid & ~stall, unless it is being loaded that edge.
REQ-017 flush SHALL force IDLE, hold_valid<=0 and stall=0 combinationally; flush wins over a simultaneous dmem_resp or hazard.
REQ-018 stall_cnt SHALL increment each cycle stall=1 and saturate at all-ones without wrapping.
REQ-019 fwd_hit, fwd_data and stall SHALL be combinational from inputs and state; there is no added latency.

Reset
REQ-020 rst SHALL asynchronously force: FSM=IDLE, hold_valid=0, hold_rd=0, hold_data=0, pend_rd=0, stall_cnt=0.
REQ-021 Reset asserted mid-LOAD_WAIT SHALL abandon the pending load; a later dmem_resp in IDLE with no hazard has no effect.

Structure
REQ-022 rv32i_types SHALL gain fwd_state_t (IDLE, LOAD_WAIT) and reuse rv32i_reg/rv32i_word for NUM_SRC=…, XLEN=32.
REQ-023 The per-source priority match/mux SHALL be the sub-module fwd_match_mux, instantiated NUM_SRC times via generate.
REQ-024 The FSM, hold register and counter SHALL live in fwd_hazard_unit.

Verification
REQ-025 ex_rs={5,6}, stage0 ALU rd=5 data=0xAA, stage1 rd=6 data=0xBB -> fwd_hit=11, data {0xAA,0xBB}, stall=0.
REQ-026 Both stages write rd=7 (0x11 in stage 0, 0x22 in stage 1), ex_rs0=7 -> 0x11; ex_rs0=0 with stage rd=0 -> fwd_hit=0.
REQ-027 Stage-0 load rd=3, ex_rs1=3, dmem_resp delayed 3 cycles (rdata 0xDEAD) -> stall high 3 cycles, fwd 0xDEAD on the 4th, stall_cnt=3, then hold forwards until EX advances.
REQ-028 Same as REQ-027 but flush asserted with dmem_resp -> stall=0, IDLE, hold_valid=0.
REQ-029 rst asserted mid-LOAD_WAIT -> all state zero immediately; CNT_W=2 with 5 stall cycles -> stall_cnt=3.
REQ-030 Run with NUM_SRC=3, NUM_STG=3 -> stage-2 match used only when stages 0/1 miss.
